seq_pattern_tx: RTL and testbench

//  Moore-FSM serial pattern transmitter: serialises a parallel bit pattern (default 4'b1001)
//  MSB-first onto a 1-bit line, repeated a programmable number of times.

---
 rtl/seq_fsm_pkg.sv | 13 +
 rtl/seq_tx_shifter.sv | 36 +++
 rtl/seq_pattern_tx.sv | 119 +++++++++++
 tb/tb_seq_pattern_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding and default pattern.
package seq_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEQ_PAT_1001 = 4'b1001;

endpackage

// File: rtl/seq_tx_shifter.sv
// PAT_W-bit MSB-first shift register with a down-counting bit index; last_bit flags index 0.
module seq_tx_shifter #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb,
  output logic             last_bit
);

  localparam int BW = $clog2(PAT_W);

  logic [PAT_W-1:0] shreg;
  logic [BW-1:0]    bitcnt;

  // Load has priority so a reload on the final bit starts the next repetition cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      shreg  <= din;
      bitcnt <= BW'(PAT_W - 1);
    end else if (shift) begin
      shreg  <= {shreg[PAT_W-2:0], 1'b0};
      bitcnt <= bitcnt - BW'(1);
    end
  end

  assign msb      = shreg[PAT_W-1];
  assign last_bit = (bitcnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Moore serial pattern transmitter: sends a captured pattern MSB-first, reps times.
// Define SEQ_TX_GUARD_EN to insert one GUARD bit (value GUARD_VAL) between repetitions.
module seq_pattern_tx
  import seq_fsm_pkg::*;
#(
  parameter int   PAT_W     = 4,
  parameter int   CNT_W     = 4
`ifdef SEQ_TX_GUARD_EN
  ,
  parameter logic GUARD_VAL = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             ready,
  output logic             dout,
  output logic             dvalid,
  output logic             done
);

  state_t           state, next;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] cnt_q;
  logic             capture, load, shift, cnt_dec;
  logic             msb, last_bit;

  seq_tx_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .din      (capture ? pattern : pat_q),
    .msb      (msb),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  // cnt_q holds the repetitions still to be sent, including the one in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      cnt_q <= '0;
    end else if (capture) begin
      pat_q <= pattern;
      cnt_q <= reps;
    end else if (cnt_dec) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    next    = state;
    capture = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    cnt_dec = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          load    = 1'b1;
          next    = (reps != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          shift = 1'b1;
        end else if (cnt_q > CNT_W'(1)) begin
          cnt_dec = 1'b1;
`ifdef SEQ_TX_GUARD_EN
          next    = ST_GUARD;
`else
          load    = 1'b1;
`endif
        end else begin
          next = ST_DONE;
        end
      end
`ifdef SEQ_TX_GUARD_EN
      ST_GUARD: begin
        load = 1'b1;
        next = ST_SHIFT;
      end
`endif
      ST_DONE: next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    dout   = 1'b0;
    dvalid = 1'b0;
    done   = 1'b0;
    case (state)
      ST_IDLE:  ready = 1'b1;
      ST_SHIFT: begin
        dvalid = 1'b1;
        dout   = msb;
      end
`ifdef SEQ_TX_GUARD_EN
      ST_GUARD: begin
        dvalid = 1'b1;
        dout   = GUARD_VAL;
      end
`endif
      ST_DONE:  done = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: vector table, hand sequences and a randomized model check.
module tb_seq_pattern_tx;
  import seq_fsm_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             ready, dout, dvalid, done;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .ready   (ready),
    .dout    (dout),
    .dvalid  (dvalid),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit got_q[$];
  int done_cyc;
  bit timed_out, ready_bad, zero_bad;
  logic ready_after, done_after;

  typedef struct {
    logic [3:0]   pat;
    logic [3:0]   n;
    int           len;
    logic [127:0] bits;
    int           z;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference stream from the frame rules: reps copies of the pattern, MSB first.
  function automatic void build_model(input logic [3:0] pat, input logic [3:0] n);
    exp_q.delete();
    for (int r = 0; r < int'(n); r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(pat[b]);
`ifdef SEQ_TX_GUARD_EN
      if (r < int'(n) - 1) exp_q.push_back(1'b0);
`endif
    end
  endfunction

  function automatic int count_1001();
    int cnt = 0;
    for (int i = 3; i < got_q.size(); i++)
      if ({got_q[i-3], got_q[i-2], got_q[i-1], got_q[i]} == 4'b1001) cnt++;
    return cnt;
  endfunction

  // Entered just after a rising edge with the DUT idle. mode 0: quiet inputs,
  // 1: random junk on start/pattern/reps mid-frame, 2: start+0110 pulsed in cycle 2.
  task automatic applyStimulus(input logic [3:0] pat, input logic [3:0] n, input int mode);
    got_q.delete();
    done_cyc  = 0;
    timed_out = 1'b0;
    ready_bad = 1'b0;
    zero_bad  = 1'b0;
    start     = 1'b1;
    pattern   = pat;
    reps      = n;
    @(posedge clk); #1;
    for (int c = 1; c <= 200; c++) begin
      if (dvalid === 1'b1) got_q.push_back(dout);
      else if (dout !== 1'b0) zero_bad = 1'b1;
      if (ready !== 1'b0) ready_bad = 1'b1;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      case (mode)
        1: begin
          start   = 1'($urandom_range(0, 1));
          pattern = 4'($urandom);
          reps    = 4'($urandom);
        end
        2: begin
          start   = (c == 2);
          pattern = (c == 2) ? 4'b0110 : pat;
        end
        default: start = 1'b0;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cyc == 0) timed_out = 1'b1;
    @(posedge clk); #1;
    ready_after = ready;
    done_after  = done;
  endtask

  task automatic verifyFrame(input string name);
    int mis = -1;
    int m;
    checkOutput({name, " timeout"}, timed_out, 0);
    checkOutput({name, " dvalid count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = m - 1; i >= 0; i--) if (got_q[i] != exp_q[i]) mis = i;
    checkOutput({name, " first wrong bit index"}, mis, -1);
    checkOutput({name, " start->done latency"}, done_cyc, exp_q.size() + 1);
    checkOutput({name, " ready low during frame"}, ready_bad, 0);
    checkOutput({name, " dout zero when not valid"}, zero_bad, 0);
    checkOutput({name, " ready after done"}, ready_after, 1);
    checkOutput({name, " done single pulse"}, done_after, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dv, dn, rd;
    logic [7:0] held_bits;

    vecs[0] = '{pat: SEQ_PAT_1001, n: 4'd1, len: 4, bits: 128'b1001, z: 1};
`ifdef SEQ_TX_GUARD_EN
    vecs[1] = '{pat: 4'b1001, n: 4'd3, len: 14, bits: 128'b10010100101001, z: 3};
    vecs[3] = '{pat: 4'b0110, n: 4'd2, len: 9,  bits: 128'b011000110, z: 0};
    vecs[5] = '{pat: 4'b1010, n: 4'd2, len: 9,  bits: 128'b101001010, z: 1};
`else
    vecs[1] = '{pat: 4'b1001, n: 4'd3, len: 12, bits: 128'b100110011001, z: 3};
    vecs[3] = '{pat: 4'b0110, n: 4'd2, len: 8,  bits: 128'b01100110, z: 1};
    vecs[5] = '{pat: 4'b1010, n: 4'd2, len: 8,  bits: 128'b10101010, z: 0};
`endif
    vecs[2] = '{pat: 4'b1001, n: 4'd0, len: 0, bits: 128'b0, z: 0};
    vecs[4] = '{pat: 4'b1111, n: 4'd1, len: 4, bits: 128'b1111, z: 0};

    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0;
    #3;
    checkOutput("reset ready", ready, 1);
    checkOutput("reset dvalid", dvalid, 0);
    checkOutput("reset dout", dout, 0);
    checkOutput("reset done", done, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      exp_q.delete();
      for (int b = vecs[i].len - 1; b >= 0; b--) exp_q.push_back(vecs[i].bits[b]);
      applyStimulus(vecs[i].pat, vecs[i].n, 0);
      verifyFrame($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d 1001 detector pulses", i), count_1001(), vecs[i].z);
    end

    // start/pattern pulsed mid-frame must not disturb the frame in flight.
    build_model(4'b1001, 4'd1);
    applyStimulus(4'b1001, 4'd1, 2);
    verifyFrame("ignore mid-frame start");

    // start held high: a new frame is accepted on every visit to IDLE.
    dv = 0; dn = 0; rd = 0; held_bits = '0;
    start = 1'b1; pattern = 4'b1001; reps = 4'd1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (dvalid === 1'b1) begin
        held_bits = {held_bits[6:0], dout};
        dv++;
      end
      if (done === 1'b1) dn++;
      if (ready === 1'b1) rd++;
    end
    start = 1'b0;
    checkOutput("held start dvalid cycles", dv, 8);
    checkOutput("held start done pulses", dn, 2);
    checkOutput("held start ready cycles", rd, 2);
    checkOutput("held start bits", held_bits, 8'b10011001);
    @(posedge clk); #1;
    checkOutput("held start released idle", ready, 1);

    // Asynchronous reset in the middle of cycle 2 of a frame.
    start = 1'b1; pattern = 4'b1101; reps = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre-reset dvalid", dvalid, 1);
    checkOutput("pre-reset dout", dout, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset dvalid", dvalid, 0);
    checkOutput("async reset dout", dout, 0);
    checkOutput("async reset ready", ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    build_model(4'b1001, 4'd2);
    applyStimulus(4'b1001, 4'd2, 0);
    verifyFrame("frame after reset");

    // Randomized frames, including the maximum repetition count, with junk inputs mid-frame.
    for (int i = 0; i < 25; i++) begin
      logic [3:0] p, n;
      p = 4'($urandom);
      n = (i == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      build_model(p, n);
      applyStimulus(p, n, 1);
      verifyFrame($sformatf("rand%0d p=%b n=%0d", i, p, n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
